// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch sequencer.
package fetch_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam int unsigned DEF_ADDR_WIDTH  = 8;
  localparam int unsigned DEF_INSTR_WIDTH = 8;
  localparam int unsigned DEF_PC_STEP     = 4;
  localparam int unsigned DEF_RESET_PC    = 0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory port plus the decode-side valid/ready handshake.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_WIDTH  = fetch_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = fetch_pkg::DEF_INSTR_WIDTH
);

  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0]  instr_pc;

  // Fetch side: drives the memory address and the decode payload.
  modport master (
    output imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_data, instr_ready
  );

  // Memory/decode side.
  modport slave (
    input  imem_addr, instr_valid, instr_out, instr_pc,
    output imem_data, instr_ready
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Two-entry ordered buffer (output register + skid) carrying instr and its pc.
module fetch_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PC_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic                  skid_valid
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic [PC_WIDTH-1:0]   skid_pc;
  logic                  fire_c;

  assign fire_c = out_valid & out_ready;

  // Upstream never presents data when both entries are full and nothing drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      out_pc     <= '0;
      skid_data  <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid && fire_c) begin
      out_data   <= skid_data;
      out_pc     <= skid_pc;
      skid_valid <= in_valid;
      if (in_valid) begin
        skid_data <= in_data;
        skid_pc   <= in_pc;
      end
    end else if (!out_valid || fire_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_pc   <= in_pc;
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_pc    <= in_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner: issues imem reads, tracks the read in flight, feeds decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned PC_STEP     = DEF_PC_STEP,
  parameter int unsigned RESET_PC    = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_sequencer_if.master     bus
);

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(PC_STEP - 1);
  localparam logic [ADDR_WIDTH-1:0] START_PC   = ADDR_WIDTH'(RESET_PC);

  fetch_state_t            state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   inflight_pc;
  logic                    inflight;
  logic                    out_valid;
  logic                    skid_valid;
  logic [INSTR_WIDTH-1:0]  out_data;
  logic [ADDR_WIDTH-1:0]   out_pc;
  logic                    fire_c;
  logic                    issue_c;
  logic [1:0]              occ_c;

  // A draining entry frees a slot in the same cycle, keeping 1 instr/cycle.
  assign fire_c  = out_valid & bus.instr_ready;
  assign occ_c   = 2'(out_valid) + 2'(skid_valid) + 2'(inflight);
  assign issue_c = (state == RUN) & ~redirect_valid & ((occ_c < 2'd2) | fire_c);

  // Run/halt FSM: follows the halt level one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (halt)  state <= HALTED;
        HALTED:  if (!halt) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // PC and in-flight tracking; redirect drops the outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= START_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ALIGN_MASK;
      inflight <= 1'b0;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        inflight_pc <= pc;
        pc          <= pc + STEP;
      end
    end
  end

  fetch_skid_buffer #(
    .DATA_WIDTH (INSTR_WIDTH),
    .PC_WIDTH   (ADDR_WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .in_valid   (inflight),
    .in_data    (bus.imem_data),
    .in_pc      (inflight_pc),
    .out_ready  (bus.instr_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_pc     (out_pc),
    .skid_valid (skid_valid)
  );

  assign bus.imem_addr   = pc;
  assign bus.instr_valid = out_valid;
  assign bus.instr_out   = out_data;
  assign bus.instr_pc    = out_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed checks of fetch_sequencer against a queue model.
module tb_fetch_sequencer;

  localparam int unsigned AW   = 8;
  localparam int unsigned IW   = 8;
  localparam int unsigned STEP = 4;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] data;
    bit            arrived;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          halt;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  fetch_sequencer #(
    .ADDR_WIDTH  (AW),
    .INSTR_WIDTH (IW),
    .PC_STEP     (STEP),
    .RESET_PC    (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  function automatic logic [IW-1:0] mem_f(logic [AW-1:0] a);
    return IW'(a + 1);
  endfunction

  // Synchronous ROM: address present at an edge, data visible after it.
  always @(posedge clk) bus.imem_data <= mem_f(bus.imem_addr);

  // Behavioural model: a queue of fetched entries, oldest first, including
  // the one still in flight (arrived=0).
  ent_t          q[$];
  logic [AW-1:0] m_pc = '0;
  bit            m_halted = 1'b0;
  int            m_occ;
  bit            m_fire;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_pc     = '0;
      m_halted = 1'b0;
    end else begin
      m_occ  = q.size();
      m_fire = (q.size() > 0) && q[0].arrived && bus.instr_ready;
      if (m_fire) void'(q.pop_front());
      foreach (q[i]) q[i].arrived = 1'b1;
      if (redirect_valid) begin
        q.delete();
        m_pc = AW'(redirect_pc - (redirect_pc % STEP));
      end else if (!m_halted && (m_occ < 2 || m_fire)) begin
        q.push_back('{pc: m_pc, data: mem_f(m_pc), arrived: 1'b0});
        m_pc = AW'(m_pc + STEP);
      end
      m_halted = halt;
    end
  end

  logic [AW-1:0] acc_pc[$];
  logic [IW-1:0] acc_data[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    bit ev;
    ev = (q.size() > 0) && q[0].arrived;
    chk("instr_valid", 32'(bus.instr_valid), 32'(ev));
    chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    if (ev) begin
      chk("instr_pc", 32'(bus.instr_pc), 32'(q[0].pc));
      chk("instr_out", 32'(bus.instr_out), 32'(q[0].data));
    end
  endtask

  // Drive one cycle of inputs, log any transfer, then check after the edge.
  task automatic step(bit r, bit rdy, bit h, bit rv, logic [AW-1:0] rpc);
    rst            = r;
    bus.instr_ready = rdy;
    halt           = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (!r && bus.instr_valid && rdy) begin
      acc_pc.push_back(bus.instr_pc);
      acc_data.push_back(bus.instr_out);
    end
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask

  // Accepted stream must be start, start+4, ... with data = pc+1.
  task automatic check_seq(string name, int start, int n);
    chk({name, "_count"}, 32'(acc_pc.size() >= n), 32'd1);
    if (acc_pc.size() >= n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, "_pc"}, 32'(acc_pc[i]), 32'((start + i * STEP) % 256));
        chk({name, "_data"}, 32'(acc_data[i]), 32'((start + i * STEP + 1) % 256));
      end
    end
  endtask

  task automatic clear_acc();
    acc_pc.delete();
    acc_data.delete();
  endtask

  initial begin
    rst             = 1'b1;
    halt            = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    bus.instr_ready = 1'b0;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_instr_out", 32'(bus.instr_out), 32'd0);
    chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);

    // Streaming from reset: valid appears on the second cycle
    clear_acc();
    step(0, 1, 0, 0, 0);
    chk("first_valid_lat1", 32'(bus.instr_valid), 32'd0);
    step(0, 1, 0, 0, 0);
    chk("first_valid_lat2", 32'(bus.instr_valid), 32'd1);
    repeat (4) step(0, 1, 0, 0, 0);
    check_seq("stream", 0, 4);

    // Backpressure for 5 cycles, then release
    repeat (5) step(0, 0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0);
    chk("stall_total", 32'(acc_pc.size()), 32'd9);
    check_seq("stall", 0, 9);

    // Redirect to 0x33 with both entries full
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8'h33);
    chk("redirect_flush", 32'(bus.instr_valid), 32'd0);
    clear_acc();
    repeat (5) step(0, 1, 0, 0, 0);
    check_seq("redirect", 8'h30, 2);

    // Wrap around the top of the address space
    step(0, 1, 0, 1, 8'd248);
    clear_acc();
    repeat (6) step(0, 1, 0, 0, 0);
    check_seq("wrap", 248, 4);

    // Halt for 4 cycles, then resume at the next sequential pc
    clear_acc();
    repeat (4) step(0, 1, 1, 0, 0);
    chk("halt_drained", 32'(bus.instr_valid), 32'd0);
    repeat (6) step(0, 1, 0, 0, 0);
    check_seq("halt", 8, 6);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0),
           AW'($urandom_range(0, 255)));
    end

    // Reset mid-stream
    repeat (5) step(0, 1, 0, 0, 0);
    chk("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
    step(1, 1, 0, 0, 0);
    chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("midrst_addr", 32'(bus.imem_addr), 32'd0);
    clear_acc();
    repeat (6) step(0, 1, 0, 0, 0);
    check_seq("restart", 0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the program counter and sequences the getInstruction instruction memory: drives its address, tracks the one-cycle read in flight, and hands fetched instructions to decode over a valid/ready handshake. A 2-entry buffer (output register plus skid) sustains 1 instr/cycle under backpressure without losing data. Handles branch redirect (flush) and halt. Sits between getInstruction and the decode stage.

Parameters:
ADDR_WIDTH, 8, width of PC and imem address
INSTR_WIDTH, 8, instruction width
PC_STEP, 4, byte increment per instruction (power of 2)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
halt  in  1  level; while 1, no new fetches are issued
redirect_valid  in  1  one-cycle pulse: load redirect_pc and flush
redirect_pc  in  ADDR_WIDTH  redirect target
imem_addr  out  ADDR_WIDTH  address to getInstruction, equals PC register
imem_data  in  INSTR_WIDTH  getInstruction read data
instr_valid  out  1  instr_out/instr_pc valid
instr_ready  in  1  decode accepts
instr_out  out  INSTR_WIDTH  instruction
instr_pc  out  ADDR_WIDTH  address it was fetched from

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, imem_addr=RESET_PC, inflight=0, out_valid=0, skid_valid=0, instr_out=0, instr_pc=0, state=RUN. rst overrides all other inputs.
- Memory timing: address on imem_addr at edge k → imem_data valid after edge k, captured at edge k+1 (latency 1).
- fire = instr_valid & instr_ready. occ = out_valid + skid_valid + inflight.
- issue = (state==RUN) & !redirect_valid & (occ<2 | fire). On issue: inflight<=1, inflight_pc<=pc, pc<=pc+PC_STEP (mod 2^ADDR_WIDTH; 252→0 at defaults). Otherwise pc holds, inflight<=0.
- Return (inflight=1): data goes to output register if empty or fire, else to skid. Skid moves to output on fire; new return then goes to skid. Order preserved; never overwrites a valid entry.
- Steady state with instr_ready=1: one instruction per cycle; first instr_valid 2 cycles after reset deassertion.
- instr_ready=0: at most 2 entries held (output + skid); issue stops; instr_out/instr_pc stable while instr_valid=1 and not accepted.
- Redirect: at the edge: out_valid, skid_valid, inflight cleared (in-flight data discarded); pc<=redirect_pc with low log2(PC_STEP) bits forced to 0; no issue that cycle. A fire coincident with redirect counts as consumed. First post-redirect instr_valid 2 cycles later.
- FSM states RUN, HALTED. RUN→HALTED when halt=1; HALTED→RUN when halt=0. In HALTED: no issue, in-flight data still captured, buffer drains normally; redirect still updates pc and flushes.
- Simultaneous redirect and halt: both take effect (pc loaded, flushed, halted).

Decomposition:
- fetch_pkg: fetch_state_t enum {RUN, HALTED}; default constants for ADDR_WIDTH, INSTR_WIDTH, PC_STEP, RESET_PC.
- Sub-module fetch_skid_buffer: 2-entry valid/ready buffer (data+pc) with flush input; fetch_sequencer holds PC, FSM, issue/in-flight logic.

Test Plan:
- Reset then instr_ready=1 for 6 cycles (mem[a]=a+1) → instr_pc 0,4,8,12,... one per cycle from cycle 2, instr_out 1,5,9,13.
- Hold instr_ready=0 for 5 cycles mid-stream → instr_valid stays 1, instr_out/instr_pc stable, imem_addr frozen; on release, next pcs follow in order, none skipped or repeated.
- Redirect pulse to 0x33 while 2 entries buffered → buffer flushed next cycle, next delivered instr_pc=0x30, then 0x34.
- Run pc to 248 → instr_pc sequence 248, 252, 0, 4 (wrap).
- Assert halt for 4 cycles with instr_ready=1 → in-flight instruction delivered, then instr_valid=0; on deassert, fetch resumes at the next sequential pc.
- Assert rst mid-stream with instr_valid=1 → next cycle instr_valid=0, imem_addr=0; sequence restarts at instr_pc=0.
